// File: rtl/canvas_cursor_ctrl_if.sv
// Pixel-write request channel between the cursor engine and pixel storage.
// Valid/ready handshake carrying the target column, row and colour.
interface canvas_cursor_ctrl_if #(
  parameter int X_W     = 6,
  parameter int Y_W     = 6,
  parameter int COLOR_W = 3
);
  logic               wr_valid;
  logic               wr_ready;
  logic [X_W-1:0]     wr_x;
  logic [Y_W-1:0]     wr_y;
  logic [COLOR_W-1:0] wr_color;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_color,
    output wr_ready
  );
endinterface

// File: rtl/canvas_cursor_ctrl.sv
// Cursor/paint engine: debounced buttons with hold-to-repeat move a cursor
// over the canvas and emit one pixel-write request per move.
module canvas_cursor_ctrl #(
  parameter int CANVAS_W      = 64,
  parameter int CANVAS_H      = 64,
  parameter int COLOR_W       = 3,
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8,
  parameter int WRAP          = 1,
  localparam int X_W = $clog2(CANVAS_W),
  localparam int Y_W = $clog2(CANVAS_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         btn,
  input  logic [COLOR_W-1:0] rgb_sel,
  input  logic               brush,
  output logic [X_W-1:0]     cur_x,
  output logic [Y_W-1:0]     cur_y,
  output logic [3:0]         drop_cnt,
  canvas_cursor_ctrl_if.master wr
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = (RMAX < 2) ? 1 : $clog2(RMAX);
  localparam int RLOAD = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int RPER  = REPEAT_PERIOD - 1;
  localparam logic [X_W-1:0] XMAX = X_W'(CANVAS_W - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(CANVAS_H - 1);
  localparam bit RPT_EN = (REPEAT_DELAY > 0);
  localparam bit WRAP_EN = (WRAP != 0);

  logic [3:0]         r_s1;
  logic [3:0]         r_s2;
  logic [3:0]         r_deb;
  logic [3:0]         r_deb_q;
  logic [DEB_W-1:0]   r_cnt [4];
  logic [RPT_W-1:0]   r_rcnt [4];
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_valid;
  logic [X_W-1:0]     r_wx;
  logic [Y_W-1:0]     r_wy;
  logic [COLOR_W-1:0] r_wc;
  logic [3:0]         r_drop;

  logic [3:0]     w_rise;
  logic [3:0]     w_held;
  logic [3:0]     w_step;
  logic [X_W-1:0] w_nx;
  logic [Y_W-1:0] w_ny;
  logic           w_move;
  logic           w_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i]  <= '0;
        r_rcnt[i] <= '0;
      end
    end else begin
      r_s1    <= btn;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_deb[i] <= ~r_deb[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        // repeat countdown restarts on press, reloads on each repeat
        if (w_rise[i]) begin
          r_rcnt[i] <= RPT_W'(RLOAD);
        end else if (w_held[i]) begin
          if (r_rcnt[i] == '0) r_rcnt[i] <= RPT_W'(RPER);
          else r_rcnt[i] <= r_rcnt[i] - 1'b1;
        end else begin
          r_rcnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_rise = r_deb & ~r_deb_q;
    w_held = r_deb & r_deb_q;
    for (int i = 0; i < 4; i++) begin
      w_step[i] = w_rise[i] |
                  (RPT_EN & w_held[i] & (r_rcnt[i] == '0));
    end
  end

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (w_step[1] && !w_step[0]) begin
      if (r_x == XMAX) w_nx = WRAP_EN ? '0 : XMAX;
      else w_nx = r_x + 1'b1;
    end else if (w_step[0] && !w_step[1]) begin
      if (r_x == '0) w_nx = WRAP_EN ? XMAX : '0;
      else w_nx = r_x - 1'b1;
    end
    if (w_step[2] && !w_step[3]) begin
      if (r_y == YMAX) w_ny = WRAP_EN ? '0 : YMAX;
      else w_ny = r_y + 1'b1;
    end else if (w_step[3] && !w_step[2]) begin
      if (r_y == '0) w_ny = WRAP_EN ? YMAX : '0;
      else w_ny = r_y - 1'b1;
    end
    w_move = (w_nx != r_x) || (w_ny != r_y);
    w_acc  = w_move && (!r_valid || wr.wr_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_wc    <= '0;
      r_drop  <= '0;
    end else if (w_acc) begin
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_valid <= 1'b1;
      r_wx    <= w_nx;
      r_wy    <= w_ny;
      r_wc    <= brush ? rgb_sel : '0;
    end else begin
      if (wr.wr_ready) r_valid <= 1'b0;
      if (w_move && r_drop != 4'hf) r_drop <= r_drop + 1'b1;
    end
  end

  assign cur_x       = r_x;
  assign cur_y       = r_y;
  assign drop_cnt    = r_drop;
  assign wr.wr_valid = r_valid;
  assign wr.wr_x     = r_wx;
  assign wr.wr_y     = r_wy;
  assign wr.wr_color = r_wc;

endmodule

// File: tb/tb_canvas_cursor_ctrl.sv
// Directed bench for canvas_cursor_ctrl on an 8x4 canvas, with a
// wrapping and a saturating instance driven by the same buttons.
module tb_canvas_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [2:0] rgb_sel;
  logic       brush;
  logic [2:0] cur_x;
  logic [1:0] cur_y;
  logic [3:0] drop_cnt;
  logic [2:0] s_cur_x;
  logic [1:0] s_cur_y;
  logic [3:0] s_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  canvas_cursor_ctrl_if #(.X_W(3), .Y_W(2), .COLOR_W(3)) wr_if ();
  canvas_cursor_ctrl_if #(.X_W(3), .Y_W(2), .COLOR_W(3)) s_if ();

  canvas_cursor_ctrl #(
    .CANVAS_W(8), .CANVAS_H(4), .COLOR_W(3), .DEB_CYCLES(3),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .WRAP(1)
  ) u_wrap (
    .clk(clk), .rst(rst), .btn(btn), .rgb_sel(rgb_sel),
    .brush(brush), .cur_x(cur_x), .cur_y(cur_y),
    .drop_cnt(drop_cnt), .wr(wr_if.master)
  );

  canvas_cursor_ctrl #(
    .CANVAS_W(8), .CANVAS_H(4), .COLOR_W(3), .DEB_CYCLES(3),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .WRAP(0)
  ) u_sat (
    .clk(clk), .rst(rst), .btn(btn), .rgb_sel(rgb_sel),
    .brush(brush), .cur_x(s_cur_x), .cur_y(s_cur_y),
    .drop_cnt(s_drop_cnt), .wr(s_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic release_btn();
    btn = 4'b0000;
    repeat (12) tick();
  endtask

  int upd [6] = '{5, 15, 19, 23, 27, 31};
  int ex;
  bit ev;

  initial begin
    rst = 1'b1;
    btn = 4'b0010;
    rgb_sel = 3'b101;
    brush = 1'b1;
    wr_if.wr_ready = 1'b1;
    s_if.wr_ready = 1'b1;

    // reset while right is held
    tick();
    tick();
    chk("rst_x", 32'(cur_x), 0);
    chk("rst_y", 32'(cur_y), 0);
    chk("rst_valid", 32'(wr_if.wr_valid), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_wcolor", 32'(wr_if.wr_color), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("redeb_hold_x", 32'(cur_x), 0);
    tick();
    chk("redeb_x", 32'(cur_x), 1);
    chk("redeb_valid", 32'(wr_if.wr_valid), 1);
    tick();
    chk("redeb_valid_clr", 32'(wr_if.wr_valid), 0);
    release_btn();

    // left at x=0: wrap vs saturate
    do_reset();
    btn = 4'b0001;
    repeat (6) tick();
    chk("wrap_x", 32'(cur_x), 7);
    chk("wrap_wx", 32'(wr_if.wr_x), 7);
    chk("wrap_valid", 32'(wr_if.wr_valid), 1);
    chk("sat_x", 32'(s_cur_x), 0);
    chk("sat_valid", 32'(s_if.wr_valid), 0);
    chk("sat_drop", 32'(s_drop_cnt), 0);
    release_btn();

    // hold-to-repeat: writes land on edges listed in upd
    do_reset();
    btn = 4'b0010;
    for (int n = 1; n <= 36; n++) begin
      tick();
      ex = 0;
      ev = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (upd[k] <= n - 1) ex++;
        if (upd[k] == n - 1) ev = 1'b1;
      end
      chk($sformatf("rpt_x_%0d", n), 32'(cur_x), 32'(ex));
      chk($sformatf("rpt_v_%0d", n), 32'(wr_if.wr_valid), 32'(ev));
      if (ev) chk("rpt_color", 32'(wr_if.wr_color), 5);
      if (n == 28) btn = 4'b0000;
    end
    release_btn();
    chk("rpt_final_x", 32'(cur_x), 6);

    // 2-cycle glitch is ignored
    btn = 4'b0010;
    tick();
    tick();
    release_btn();
    chk("glitch_x", 32'(cur_x), 6);
    chk("glitch_valid", 32'(wr_if.wr_valid), 0);

    // erase move down
    brush = 1'b0;
    btn = 4'b0100;
    repeat (6) tick();
    chk("erase_y", 32'(cur_y), 1);
    chk("erase_wy", 32'(wr_if.wr_y), 1);
    chk("erase_color", 32'(wr_if.wr_color), 0);
    chk("erase_valid", 32'(wr_if.wr_valid), 1);
    release_btn();

    // backpressure
    do_reset();
    wr_if.wr_ready = 1'b0;
    btn = 4'b0010;
    repeat (6) tick();
    chk("bp_x1", 32'(cur_x), 1);
    release_btn();
    chk("bp_valid_hold", 32'(wr_if.wr_valid), 1);
    btn = 4'b0010;
    repeat (6) tick();
    chk("bp_x", 32'(cur_x), 1);
    chk("bp_wx", 32'(wr_if.wr_x), 1);
    chk("bp_valid", 32'(wr_if.wr_valid), 1);
    chk("bp_drop", 32'(drop_cnt), 1);
    release_btn();
    wr_if.wr_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(wr_if.wr_valid), 0);

    // up+down cancel
    btn = 4'b1100;
    repeat (6) tick();
    chk("cancel_y", 32'(cur_y), 0);
    chk("cancel_valid", 32'(wr_if.wr_valid), 0);
    release_btn();

    // diagonal from (0,1)
    do_reset();
    btn = 4'b0100;
    repeat (6) tick();
    release_btn();
    btn = 4'b1010;
    repeat (6) tick();
    chk("diag_x", 32'(cur_x), 1);
    chk("diag_y", 32'(cur_y), 0);
    chk("diag_wx", 32'(wr_if.wr_x), 1);
    chk("diag_wy", 32'(wr_if.wr_y), 0);
    chk("diag_valid", 32'(wr_if.wr_valid), 1);
    tick();
    chk("diag_single", 32'(wr_if.wr_valid), 0);
    release_btn();

    // reset with a pending write
    wr_if.wr_ready = 1'b0;
    btn = 4'b0010;
    repeat (6) tick();
    chk("pend_valid", 32'(wr_if.wr_valid), 1);
    btn = 4'b0000;
    rst = 1'b1;
    tick();
    chk("rstmid_valid", 32'(wr_if.wr_valid), 0);
    chk("rstmid_x", 32'(cur_x), 0);
    chk("rstmid_y", 32'(cur_y), 0);
    rst = 1'b0;
    wr_if.wr_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
